// File: rtl/miner_pkg.sv
// Shared constants, state encoding and helpers for the miner work loader.
// Header geometry is expressed in bytes and derived bit widths.
package miner_pkg;

    localparam logic [7:0] SYNC_WORK  = 8'hAA;
    localparam logic [7:0] SYNC_STOP  = 8'h55;

    localparam int HDR_BYTES  = 76;
    localparam int BLK1_BYTES = 64;
    localparam int BLK2_BYTES = HDR_BYTES - BLK1_BYTES;

    localparam int HDR_BITS  = HDR_BYTES * 8;
    localparam int BLK1_BITS = BLK1_BYTES * 8;
    localparam int BLK2_BITS = BLK2_BYTES * 8;

    localparam logic [6:0] LAST_BYTE_IDX = 7'(HDR_BYTES - 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_COMMIT  = 2'd3
    } loader_state_e;

    // Error counter increment that sticks at the top value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/miner_timeout_counter.sv
// Idle-cycle counter: asserts expired on the cycle whose idle edge would
// bring the count up to TIMEOUT_CYCLES.
module miner_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] CNT_ONE  = W'(1);
    localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0] CNT_MAX  = W'(TIMEOUT_CYCLES);

    logic [W-1:0] r_count;

    // Idle counter, held at the limit so it can never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_en && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign expired = count_en && !clear && (r_count == CNT_LAST);

endmodule

// File: rtl/miner_work_loader.sv
// Assembles checksum-verified 76-byte block headers from a framed byte
// stream and drives the blk1/blk2/enable inputs of miner_core.
module miner_work_loader
    import miner_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic [7:0]     in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [511:0]   blk1,
    output logic [95:0]    blk2,
    output logic           enable,
    output logic           miner_restart,
    output logic [7:0]     frame_err_cnt
);

    loader_state_e          r_state;
    logic [6:0]             r_byte_cnt;
    logic [7:0]             r_xor;
    logic [HDR_BITS-1:0]    r_shadow;
    logic [BLK1_BITS-1:0]   r_blk1;
    logic [BLK2_BITS-1:0]   r_blk2;
    logic                   r_enable;
    logic                   r_restart;
    logic                   r_stop_pend;
    logic [7:0]             r_err_cnt;

    logic w_accept;
    logic w_in_frame;
    logic w_to_clear;
    logic w_to_count;
    logic w_expired;

    assign in_ready   = !reset && (r_state != ST_COMMIT);
    assign w_accept   = in_valid && in_ready;
    assign w_in_frame = (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);
    // An accepted byte always beats an expiring timeout.
    assign w_to_clear = !w_in_frame || w_accept;
    assign w_to_count = w_in_frame && !w_accept;

    miner_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (CLOCK_50),
        .reset    (reset),
        .clear    (w_to_clear),
        .count_en (w_to_count),
        .expired  (w_expired)
    );

    // Frame state machine with checksum, shadow header and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= ST_HUNT;
            r_byte_cnt  <= 7'd0;
            r_xor       <= 8'd0;
            r_shadow    <= '0;
            r_blk1      <= '0;
            r_blk2      <= '0;
            r_enable    <= 1'b0;
            r_restart   <= 1'b0;
            r_stop_pend <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_restart   <= 1'b0;
            r_stop_pend <= 1'b0;
            // A stop takes effect one cycle after the stop byte is taken.
            if (r_stop_pend) begin
                r_enable <= 1'b0;
            end else begin
                r_enable <= r_enable;
            end
            case (r_state)
                ST_HUNT: begin
                    if (w_accept && (in_data == SYNC_WORK)) begin
                        r_state    <= ST_PAYLOAD;
                        r_byte_cnt <= 7'd0;
                        r_xor      <= 8'd0;
                    end else if (w_accept && (in_data == SYNC_STOP)) begin
                        r_stop_pend <= 1'b1;
                    end else begin
                        r_state <= ST_HUNT;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_accept) begin
                        r_shadow <= {r_shadow[HDR_BITS-9:0], in_data};
                        r_xor    <= r_xor ^ in_data;
                        if (r_byte_cnt == LAST_BYTE_IDX) begin
                            r_byte_cnt <= 7'd0;
                            r_state    <= ST_CHECK;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 7'd1;
                        end
                    end else if (w_expired) begin
                        r_state   <= ST_HUNT;
                        r_err_cnt <= sat_inc8(r_err_cnt);
                    end else begin
                        r_state <= ST_PAYLOAD;
                    end
                end
                ST_CHECK: begin
                    if (w_accept && (in_data == r_xor)) begin
                        r_state <= ST_COMMIT;
                    end else if (w_accept) begin
                        r_state   <= ST_HUNT;
                        r_err_cnt <= sat_inc8(r_err_cnt);
                    end else if (w_expired) begin
                        r_state   <= ST_HUNT;
                        r_err_cnt <= sat_inc8(r_err_cnt);
                    end else begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_COMMIT: begin
                    r_blk1    <= r_shadow[HDR_BITS-1 -: BLK1_BITS];
                    r_blk2    <= r_shadow[BLK2_BITS-1:0];
                    r_enable  <= 1'b1;
                    r_restart <= 1'b1;
                    r_state   <= ST_HUNT;
                end
                default: begin
                    r_state <= ST_HUNT;
                end
            endcase
        end
    end

    assign blk1          = r_blk1;
    assign blk2          = r_blk2;
    assign enable        = r_enable;
    assign miner_restart = r_restart;
    assign frame_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_miner_work_loader.sv
// Randomized scoreboard bench for miner_work_loader: the driver pushes the
// header each good frame should commit, a monitor pops it on miner_restart.
module tb_miner_work_loader;

    localparam int TO = 100;

    logic           CLOCK_50 = 1'b0;
    logic           reset;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_ready;
    logic [511:0]   blk1;
    logic [95:0]    blk2;
    logic           enable;
    logic           miner_restart;
    logic [7:0]     frame_err_cnt;

    miner_work_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .blk1          (blk1),
        .blk2          (blk2),
        .enable        (enable),
        .miner_restart (miner_restart),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [511:0] b1;
        logic [95:0]  b2;
    } hdr_t;

    int           n_vec = 0;
    int           n_bad = 0;
    hdr_t         exp_q[$];
    hdr_t         mon_h;
    logic [511:0] cur_b1 = '0;
    logic [95:0]  cur_b2 = '0;
    logic         model_en = 1'b0;
    int           model_err = 0;
    logic [7:0]   pay [76];
    int           gap_max = 0;
    bit           hold_valid = 1'b0;
    logic         mon_prev = 1'b0;

    task automatic check(input string name, input logic [607:0] act, input logic [607:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every restart pulse must match the oldest expected header.
    always @(negedge CLOCK_50) begin
        if (reset) begin
            mon_prev = 1'b0;
        end else begin
            if (miner_restart) begin
                check("restart_single_cycle", mon_prev, 0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL restart_unexpected: got restart=1 expected no commit at %0t", $time);
                end else begin
                    mon_h = exp_q.pop_front();
                    check("commit_blk1", blk1, mon_h.b1);
                    check("commit_blk2", blk2, mon_h.b2);
                    check("commit_enable", enable, 1);
                end
            end
            mon_prev = miner_restart;
        end
    end

    function automatic logic [7:0] xor_of_payload();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 76; i++) x = x ^ pay[i];
        return x;
    endfunction

    task automatic fill_payload(input bit ramp);
        for (int i = 0; i < 76; i++) pay[i] = ramp ? 8'(i) : 8'($urandom_range(0, 255));
    endtask

    task automatic bump_err();
        if (model_err < 255) model_err++;
    endtask

    task automatic send_byte(input logic [7:0] b, output int stalls);
        bit acc = 1'b0;
        stalls = 0;
        if (gap_max > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(posedge CLOCK_50);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge CLOCK_50);
            if (in_ready) begin
                @(posedge CLOCK_50);
                #1;
                acc = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got no acceptance expected byte %0h taken", b);
        end
        if (!hold_valid) in_valid = 1'b0;
    endtask

    // Sends one work frame from pay[]; gap_at >= 0 inserts an idle gap before that payload byte.
    task automatic send_frame(input logic [7:0] chk, input bit timing, input int gap_at,
                              input int gap_len, output int first_stall);
        int   s;
        bit   good;
        hdr_t h;
        send_byte(8'hAA, first_stall);
        for (int i = 0; i < 76; i++) begin
            if (i == gap_at) begin
                in_valid = 1'b0;
                repeat (gap_len) @(posedge CLOCK_50);
                #1;
            end
            send_byte(pay[i], s);
        end
        good = (chk == xor_of_payload());
        if (good) begin
            for (int i = 0; i < 64; i++) h.b1[511 - 8*i -: 8] = pay[i];
            for (int i = 0; i < 12; i++) h.b2[95 - 8*i -: 8] = pay[64 + i];
            exp_q.push_back(h);
            cur_b1   = h.b1;
            cur_b2   = h.b2;
        end else begin
            bump_err();
        end
        send_byte(chk, s);
        if (timing && good) begin
            check("commit_in_ready_low", in_ready, 0);
            check("restart_not_early", miner_restart, 0);
            @(posedge CLOCK_50); #1;
            check("restart_high", miner_restart, 1);
            @(posedge CLOCK_50); #1;
            check("restart_dropped", miner_restart, 0);
        end else if (timing) begin
            check("bad_err_cnt", frame_err_cnt, model_err);
            check("bad_blk1_kept", blk1, cur_b1);
            check("bad_blk2_kept", blk2, cur_b2);
            check("bad_enable_kept", enable, model_en);
        end
        if (good) model_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int st2;
        logic [7:0] nb;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_blk1", blk1, 0);
        check("reset_blk2", blk2, 0);
        check("reset_enable", enable, 0);
        check("reset_restart", miner_restart, 0);
        check("reset_err", frame_err_cnt, 0);
        reset = 1'b0;
        @(posedge CLOCK_50); #1;
        check("idle_in_ready", in_ready, 1);

        // Ramp frame, then the same payload with a wrong checksum.
        fill_payload(1'b1);
        send_frame(8'h00, 1'b1, -1, 0, st);
        check("good_enable", enable, 1);
        send_frame(8'h01, 1'b1, -1, 0, st);
        fill_payload(1'b0);
        send_frame(xor_of_payload(), 1'b1, -1, 0, st);

        // Noise bytes, then a stop command.
        send_byte(8'h12, st);
        send_byte(8'h34, st);
        send_byte(8'h55, st);
        check("stop_enable_still_on", enable, model_en);
        @(posedge CLOCK_50); #1;
        model_en = 1'b0;
        check("stop_enable_off", enable, model_en);
        check("stop_blk1_kept", blk1, cur_b1);
        check("stop_blk2_kept", blk2, cur_b2);
        check("stop_err_kept", frame_err_cnt, model_err);

        // Timeout: 10 payload bytes, then 100 idle cycles abandons the frame.
        send_byte(8'hAA, st);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), st);
        repeat (TO) @(posedge CLOCK_50);
        #1;
        bump_err();
        check("timeout_err", frame_err_cnt, model_err);
        check("timeout_enable", enable, model_en);
        fill_payload(1'b0);
        send_frame(xor_of_payload(), 1'b1, -1, 0, st);

        // A gap one cycle short of the timeout keeps the frame alive.
        fill_payload(1'b0);
        send_frame(xor_of_payload(), 1'b1, 30, TO - 1, st);
        check("near_timeout_err", frame_err_cnt, model_err);

        // Reset after 40 payload bytes.
        send_byte(8'hAA, st);
        for (int i = 0; i < 40; i++) send_byte(8'($urandom_range(0, 255)), st);
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        cur_b1 = '0; cur_b2 = '0; model_en = 1'b0; model_err = 0;
        check("midreset_blk1", blk1, cur_b1);
        check("midreset_blk2", blk2, cur_b2);
        check("midreset_enable", enable, 0);
        check("midreset_err", frame_err_cnt, 0);
        reset = 1'b0;
        @(posedge CLOCK_50); #1;
        fill_payload(1'b1);
        send_frame(8'h00, 1'b1, -1, 0, st);

        // Back-to-back frames with in_valid held high across the commit.
        hold_valid = 1'b1;
        fill_payload(1'b0);
        send_frame(xor_of_payload(), 1'b0, -1, 0, st);
        fill_payload(1'b0);
        send_frame(xor_of_payload(), 1'b0, -1, 0, st2);
        check("backpressure_stall", st2, 1);
        hold_valid = 1'b0;
        in_valid   = 1'b0;
        repeat (3) @(posedge CLOCK_50); #1;

        // Random frames with random gaps, noise and occasional bad checksums.
        gap_max = 2;
        for (int f = 0; f < 12; f++) begin
            nb = 8'($urandom_range(0, 255));
            if (nb != 8'hAA && nb != 8'h55) send_byte(nb, st);
            fill_payload(1'b0);
            if ($urandom_range(0, 3) == 0)
                send_frame(xor_of_payload() ^ 8'($urandom_range(1, 255)), 1'b1, -1, 0, st);
            else
                send_frame(xor_of_payload(), 1'b1, -1, 0, st);
        end
        gap_max = 0;

        // Saturation of the error counter.
        for (int f = 0; f < 260; f++) begin
            fill_payload(1'b0);
            send_frame(xor_of_payload() ^ 8'h80, 1'b0, -1, 0, st);
        end
        check("saturated_err", frame_err_cnt, 255);
        check("saturated_model", frame_err_cnt, model_err);
        check("saturated_blk1_kept", blk1, cur_b1);

        repeat (5) @(posedge CLOCK_50);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/miner_work_loader.md
# miner_work_loader

Receives mining work as a framed byte stream and assembles the 76-byte block header that `miner_core` hashes. The first 64 header bytes form `blk1`, the last 12 form `blk2`; the core iterates the nonce itself. Frames are checksum-verified before the core sees them. A good frame restarts the core on the new work; a stop command halts it. The block sits directly upstream of `miner_core` and drives its `blk1`, `blk2` and `enable` inputs.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50_000_000: idle cycles allowed between accepted bytes inside a frame before it is abandoned (1 s at 50 MHz).

Ports:
- `CLOCK_50`  in  1  system clock; the single clock of this block.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  received byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte when `in_valid && in_ready`.
- `blk1`  out  512  header bytes 0..63; byte 0 is in `[511:504]`.
- `blk2`  out  96  header bytes 64..75; byte 64 is in `[95:88]`.
- `enable`  out  1  miner enable level.
- `miner_restart`  out  1  one-cycle pulse when new work is committed.
- `frame_err_cnt`  out  8  saturating count of bad or timed-out frames.

## Operation
- Frame formats:
  - Work frame: `SYNC_WORK` (0xAA), then 76 payload bytes, then a checksum byte equal to the XOR of the 76 payload bytes.
  - Stop command: the single byte `SYNC_STOP` (0x55).
- State machine: HUNT, PAYLOAD, CHECK, COMMIT.
- HUNT:
  - 0xAA → PAYLOAD; byte counter cleared; running XOR cleared.
  - 0x55 → `enable` cleared in the next cycle; `blk1`/`blk2` retained; remain in HUNT.
  - Any other byte is discarded silently.
- PAYLOAD:
  - Each accepted byte shifts into a 608-bit shadow register, MSB-first, and is XORed into the running checksum.
  - After byte 75 is accepted (counter wraps from 75) → CHECK.
  - Sync values appearing inside the payload are ordinary data.
- CHECK: the next accepted byte is compared with the running XOR.
  - Match → COMMIT.
  - Mismatch → `frame_err_cnt`+1, → HUNT; outputs unchanged.
- COMMIT (exactly one cycle):
  - `blk1`/`blk2` load from the shadow register.
  - `enable` becomes 1.
  - `miner_restart` is 1.
  - `in_ready` is 0.
  - Then → HUNT.
- Timeout:
  - In PAYLOAD or CHECK, the idle counter increments every cycle without an accepted byte and clears on each accepted byte.
  - Reaching `TIMEOUT_CYCLES` → HUNT, `frame_err_cnt`+1.
- `frame_err_cnt` saturates at 255 and is never cleared except by reset.
- Outputs only change on COMMIT or stop. A partially received frame never reaches `miner_core`.

## Timing
- Reset values: state HUNT, `blk1`=0, `blk2`=0, `enable`=0, `miner_restart`=0, `frame_err_cnt`=0, shadow register=0, counters=0.
- `in_ready` is 0 while `reset` is high. It is 1 in HUNT, PAYLOAD and CHECK, and 0 in COMMIT. It is decoded from the state.
- Latency: the checksum byte is accepted at edge N. `blk1`, `blk2`, `enable` and `miner_restart` are updated at edge N+1 and stay visible for cycle N+1. `miner_restart` drops at edge N+2.
- Stop latency: 0x55 is accepted at edge N; `enable` is 0 from edge N+1.
- Throughput: one byte per cycle. A full frame takes 78 accepted bytes plus the COMMIT cycle.
- Simultaneous events:
  - Timeout expiring in the same cycle a byte is accepted: the byte wins and the idle counter clears.
  - Error increment while the count is at 255: the count holds at 255.
- Reset mid-frame: all state returns to reset values immediately. The partial frame is lost and not counted as an error.

## Structure
- Package `miner_pkg` holds:
  - `SYNC_WORK`, `SYNC_STOP`
  - `HDR_BYTES`=76, `BLK1_BYTES`=64
  - the loader state encoding
- Sub-module `miner_timeout_counter`: idle counter with `clear`, `count_en` and `expired` signals, parameterised by `TIMEOUT_CYCLES`, width `$clog2(TIMEOUT_CYCLES+1)`.
- The FSM, byte counter (7 bits), XOR accumulator and shadow register stay in the top module.

## Test plan
- Good frame: send 0xAA, payload 0x00..0x4B, checksum 0x00.
  - `blk1` = 0x00010203…3F and `blk2` = 0x404142…4B.
  - `enable`=1; `miner_restart` high for exactly one cycle; `in_ready`=0 in that cycle.
- Bad checksum: same frame with checksum 0x01.
  - `blk1`/`blk2`/`enable` unchanged; `frame_err_cnt`=1; the next good frame commits.
- Stop command: send 0x12, 0x34, then 0x55 after a committed frame.
  - `enable`=0 one cycle after 0x55; `blk1`/`blk2` retain the committed values; `frame_err_cnt` unchanged.
- Timeout (`TIMEOUT_CYCLES`=100): send 0xAA plus 10 bytes, then idle 100 cycles.
  - State returns to HUNT; `frame_err_cnt`=1; a subsequent good frame commits.
- Reset mid-frame after 40 payload bytes.
  - All outputs are 0; `frame_err_cnt`=0; a fresh full frame commits correctly.
- Backpressure: hold `in_valid` high with back-to-back frames.
  - The first byte of frame 2 is not accepted during COMMIT and is taken the following cycle.
- Saturation: 260 bad frames.
  - `frame_err_cnt`=255.
